// File: rtl/mask_builder.sv
// Builds a WIDTH-bit mask from a stream of set/clear/toggle index beats and commits it on "last".
// One-cycle commit latency; the output register plus one pending slot absorb two masks under backpressure.
module mask_builder #(
  parameter  int WIDTH = 8,
  localparam int IW    = $clog2(WIDTH),
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW-1:0]    in_idx,
  input  logic [1:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mask,
  output logic [CW-1:0]    out_count,
  output logic             out_err
);

  typedef enum logic {S_ACCUM = 1'b0, S_WAIT = 1'b1} state_e;

  localparam logic [IW:0] LIMIT = (IW + 1)'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CW-1:0]    count_q, count_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] onehot;
  logic [WIDTH-1:0] next_acc;
  logic             in_range;
  logic             accept;
  logic             commit;
  logic             direct;
  logic             out_take;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CW'(v[i]);
    end
    return cnt;
  endfunction

  assign in_range = ({1'b0, in_idx} < LIMIT);
  assign accept   = in_valid && (state_q == S_ACCUM);
  assign commit   = accept && in_last;
  assign direct   = !vld_q || out_ready;
  assign out_take = vld_q && out_ready;

  always_comb begin
    onehot   = WIDTH'(1) << in_idx;
    next_acc = acc_q;
    if (in_range) begin
      case (in_op)
        2'b00:   next_acc = acc_q | onehot;
        2'b01:   next_acc = acc_q & ~onehot;
        2'b10:   next_acc = acc_q ^ onehot;
        default: next_acc = acc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ACCUM;
      acc_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      count_q <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  // A commit that cannot land in the busy output register parks in pend and stalls input.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACCUM: if (commit && !direct) state_d = S_WAIT;
      S_WAIT:  if (out_take) state_d = S_ACCUM;
      default: state_d = S_ACCUM;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    pend_d  = pend_q;
    mask_d  = mask_q;
    count_d = count_q;
    vld_d   = vld_q;
    err_d   = err_q;
    if (accept && !in_range) err_d = 1'b1;
    if (accept) acc_d = in_last ? '0 : next_acc;
    if (commit && direct) begin
      mask_d  = next_acc;
      count_d = popcount(next_acc);
      vld_d   = 1'b1;
    end else if (commit) begin
      pend_d = next_acc;
    end else if (state_q == S_WAIT && out_take) begin
      mask_d  = pend_q;
      count_d = popcount(pend_q);
    end else if (out_take) begin
      vld_d = 1'b0;
    end
  end

  always_comb begin
    in_ready  = (state_q == S_ACCUM);
    out_valid = vld_q;
    out_mask  = mask_q;
    out_count = count_q;
    out_err   = err_q;
  end

endmodule

// File: tb/tb_mask_builder.sv
// Randomized and directed bench for mask_builder, checked against a queue-based model (WIDTH=8 and WIDTH=6).
module tb_mask_builder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8
  logic       a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_err;
  logic [2:0] a_in_idx;
  logic [1:0] a_in_op;
  logic [7:0] a_out_mask;
  logic [3:0] a_out_count;

  // Instance B: WIDTH=6
  logic       b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_err;
  logic [2:0] b_in_idx;
  logic [1:0] b_in_op;
  logic [5:0] b_out_mask;
  logic [2:0] b_out_count;

  mask_builder #(.WIDTH(8)) u_dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_idx(a_in_idx),
    .in_op(a_in_op), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_mask(a_out_mask),
    .out_count(a_out_count), .out_err(a_out_err)
  );

  mask_builder #(.WIDTH(6)) u_dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_idx(b_in_idx),
    .in_op(b_in_op), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_mask(b_out_mask),
    .out_count(b_out_count), .out_err(b_out_err)
  );

  int checks = 0;
  int errors = 0;
  int sel    = 0;

  // Model: committed masks waiting at the output, oldest first; at most two.
  logic [7:0] m_q[$];
  logic [7:0] m_acc;
  logic       m_err;

  logic       o_ready, o_vld, o_err;
  logic [7:0] o_mask;
  logic [3:0] o_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic sample();
    if (sel == 0) begin
      o_ready = a_in_ready; o_vld = a_out_valid; o_err = a_out_err;
      o_mask  = a_out_mask; o_cnt = a_out_count;
    end else begin
      o_ready = b_in_ready; o_vld = b_out_valid; o_err = b_out_err;
      o_mask  = {2'b00, b_out_mask}; o_cnt = {1'b0, b_out_count};
    end
  endtask

  task automatic step(input logic v, input logic [2:0] idx, input logic [1:0] op,
                      input logic last, input logic rdy);
    int         w;
    logic       accept, take;
    logic [7:0] nxt;
    w = (sel == 0) ? 8 : 6;
    a_in_valid = (sel == 0) && v; a_in_idx = idx; a_in_op = op; a_in_last = last;
    a_out_ready = (sel == 0) ? rdy : 1'b1;
    b_in_valid = (sel == 1) && v; b_in_idx = idx; b_in_op = op; b_in_last = last;
    b_out_ready = (sel == 1) ? rdy : 1'b1;
    @(posedge clk);
    if (reset) begin
      m_q.delete();
      m_acc = '0;
      m_err = 1'b0;
    end else begin
      accept = v && (m_q.size() < 2);
      take   = (m_q.size() > 0) && rdy;
      if (take) void'(m_q.pop_front());
      if (accept) begin
        nxt = m_acc;
        if (int'(idx) >= w) m_err = 1'b1;
        else if (op == 2'd0) nxt[idx] = 1'b1;
        else if (op == 2'd1) nxt[idx] = 1'b0;
        else if (op == 2'd2) nxt[idx] = ~nxt[idx];
        if (last) begin
          m_q.push_back(nxt);
          m_acc = '0;
        end else begin
          m_acc = nxt;
        end
      end
    end
    #1;
    sample();
    check("in_ready", 32'(o_ready), 32'(m_q.size() < 2));
    check("out_valid", 32'(o_vld), 32'(m_q.size() > 0));
    check("out_err", 32'(o_err), 32'(m_err));
    if (m_q.size() > 0) begin
      check("out_mask", 32'(o_mask), 32'(m_q[0]));
      check("out_count", 32'(o_cnt), 32'($countones(m_q[0])));
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 3'd0, 2'd0, 1'b0, rdy);
  endtask

  task automatic pulse_reset(input logic v);
    reset = 1'b1;
    step(v, 3'd5, 2'd0, 1'b0, 1'b1);
    reset = 1'b0;
    check("rst_mask", 32'(o_mask), 32'd0);
    check("rst_count", 32'(o_cnt), 32'd0);
  endtask

  task automatic random_run(input int n, input logic allow_reset);
    for (int i = 0; i < n; i++) begin
      if (allow_reset && $urandom_range(0, 99) == 0) reset = 1'b1;
      step($urandom_range(0, 3) != 0, 3'($urandom), 2'($urandom),
           $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6);
      reset = 1'b0;
    end
  endtask

  initial begin
    m_acc = '0;
    m_err = 1'b0;
    sel = 0;
    idle(1'b1);
    pulse_reset(1'b0);

    // Basic build
    step(1'b1, 3'd3, 2'd0, 1'b0, 1'b1);
    step(1'b1, 3'd5, 2'd0, 1'b0, 1'b1);
    step(1'b1, 3'd0, 2'd0, 1'b1, 1'b1);
    check("basic_mask", 32'(o_mask), 32'h29);
    check("basic_count", 32'(o_cnt), 32'd3);
    idle(1'b1);
    check("basic_drop", 32'(o_vld), 32'd0);

    // Ops
    step(1'b1, 3'd7, 2'd0, 1'b0, 1'b1);
    step(1'b1, 3'd7, 2'd2, 1'b0, 1'b1);
    step(1'b1, 3'd2, 2'd2, 1'b0, 1'b1);
    step(1'b1, 3'd6, 2'd1, 1'b1, 1'b1);
    check("ops_mask", 32'(o_mask), 32'h04);
    step(1'b1, 3'd0, 2'd3, 1'b1, 1'b1);
    check("noop_mask", 32'(o_mask), 32'h00);
    check("noop_valid", 32'(o_vld), 32'd1);
    idle(1'b1);

    // Backpressure
    step(1'b1, 3'd0, 2'd0, 1'b1, 1'b0);
    step(1'b1, 3'd7, 2'd0, 1'b1, 1'b0);
    idle(1'b0);
    check("bp_held", 32'(o_mask), 32'h01);
    check("bp_stall", 32'(o_ready), 32'd0);
    idle(1'b1);
    check("bp_second", 32'(o_mask), 32'h80);
    check("bp_ready_back", 32'(o_ready), 32'd1);
    idle(1'b1);

    // Reset mid-operation
    step(1'b1, 3'd4, 2'd0, 1'b0, 1'b1);
    pulse_reset(1'b1);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_vld), 32'd0);
    step(1'b1, 3'd2, 2'd0, 1'b1, 1'b1);
    check("rst_clean", 32'(o_mask), 32'h04);

    // Streaming
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i), 2'd0, 1'b1, 1'b1);
      check("stream_mask", 32'(o_mask), 32'(1) << i);
    end
    idle(1'b1);

    random_run(1500, 1'b1);

    // WIDTH=6: out-of-range indices
    sel = 1;
    pulse_reset(1'b0);
    step(1'b1, 3'd6, 2'd0, 1'b0, 1'b1);
    step(1'b1, 3'd1, 2'd0, 1'b1, 1'b1);
    check("oor_mask", 32'(o_mask), 32'h02);
    check("oor_err", 32'(o_err), 32'd1);
    step(1'b1, 3'd3, 2'd0, 1'b1, 1'b1);
    check("oor_sticky", 32'(o_err), 32'd1);
    random_run(1000, 1'b0);
    pulse_reset(1'b0);
    check("oor_cleared", 32'(o_err), 32'd0);
    random_run(800, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
